// File: rtl/adex_pkg.sv
// Shared types, constants and saturation helper for the time-multiplexed AdEx neuron array.
package adex_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    UPDATE,
    DONE
  } state_t;

  localparam logic [1:0] CFG_V_REST  = 2'd0;
  localparam logic [1:0] CFG_V_T     = 2'd1;
  localparam logic [1:0] CFG_V_RESET = 2'd2;
  localparam logic [1:0] CFG_B       = 2'd3;

  localparam int V_REST_DEF  = -1024;
  localparam int V_T_DEF     = 512;
  localparam int V_RESET_DEF = -768;
  localparam int B_DEF       = 64;

  localparam int LUT_W   = 11;
  localparam int LUT_MAX = 2047;

  // Clamp a wide signed value into the signed range of a vw-bit word.
  function automatic logic signed [31:0] sat_vw(input logic signed [31:0] x, input int vw);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (vw - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (vw - 1));
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

endpackage

// File: rtl/adex_exp_lut.sv
// Exponential term ROM: entry k = round(2^(k*5/LUT_DEPTH)), capped at LUT_MAX; contents built at elaboration.
module adex_exp_lut
  import adex_pkg::*;
#(
  parameter int LUT_DEPTH = 32,
  localparam int LW = $clog2(LUT_DEPTH)
) (
  input  logic [LW-1:0]    idx,
  output logic [LUT_W-1:0] value
);

  function automatic int lut_entry(input int k);
    real x;
    int  r;
    x = 2.0 ** (real'(k) * 5.0 / real'(LUT_DEPTH));
    r = $rtoi(x + 0.5);
    return (r > LUT_MAX) ? LUT_MAX : r;
  endfunction

  logic [LUT_W-1:0] rom [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
    localparam int VAL = lut_entry(k);
    assign rom[k] = LUT_W'(VAL);
  end

  assign value = rom[idx];

endmodule

// File: rtl/adex_neuron_array.sv
// N_NEURONS AdEx neurons sharing one fixed-point datapath, with run-time constants.
// Optional refractory countdown per neuron when ADEX_REFRACTORY_EN is defined.
module adex_neuron_array
  import adex_pkg::*;
#(
  parameter int N_NEURONS  = 4,
  parameter int VW         = 16,
  parameter int IW         = 8,
  parameter int LUT_DEPTH  = 32,
  parameter int G_SHIFT    = 4,
  parameter int W_SHIFT    = 2,
  parameter int A_SHIFT    = 3,
  parameter int TAUW_SHIFT = 5,
`ifdef ADEX_REFRACTORY_EN
  parameter int REFR_ROUNDS = 3,
`endif
  parameter logic signed [VW-1:0] V_PEAK = 16'sd2048,
  localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic [N_NEURONS*IW-1:0]  i_syn,
  input  logic                     cfg_we,
  input  logic [1:0]               cfg_addr,
  input  logic [VW-1:0]            cfg_data,
  input  logic [NW-1:0]            mon_sel,
  output logic                     busy,
  output logic                     done,
  output logic [N_NEURONS-1:0]     spike,
  output logic [VW-1:0]            mon_v
);

  localparam int XW = VW + 2;
  localparam int LW = $clog2(LUT_DEPTH);

  state_t state, state_next;
  logic [NW-1:0]            n;
  logic                     last;
  logic [N_NEURONS*IW-1:0]  i_cap;
  logic [N_NEURONS-1:0]     spike_acc;
  logic signed [VW-1:0]     v_mem [N_NEURONS];
  logic signed [VW-1:0]     w_mem [N_NEURONS];
  logic signed [VW-1:0]     v_rest, v_t, v_reset, b_cfg;
  logic signed [VW-1:0]     v_r, w_r;
  logic                     ge_t;
  logic [LW-1:0]            lut_idx, idx_next;
  logic [LUT_W-1:0]         lut_val;
  logic signed [XW-1:0]     idx_full;
  logic signed [XW-1:0]     v_x, w_x, rest_x, b_x, i_x, leak, exp_x;
  logic signed [XW-1:0]     v_sum, w_sum, w_spk_sum;
  logic signed [VW-1:0]     v_new, w_new, w_spk;
  logic [IW-1:0]            i_cur;
  logic                     spike_now;
  logic                     refr_active;

  assign last = (n == NW'(N_NEURONS - 1));
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    unique case (state)
      IDLE:    if (tick) state_next = FETCH;
      FETCH:   state_next = UPDATE;
      UPDATE:  state_next = last ? DONE : FETCH;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Index is only meaningful when v >= V_T; ge_t gates the term otherwise.
  always_comb begin
    idx_full = (XW'(v_mem[n]) - XW'(v_t)) >>> 4;
    idx_next = (idx_full > XW'(LUT_DEPTH - 1)) ? LW'(LUT_DEPTH - 1) : idx_full[LW-1:0];
  end

  adex_exp_lut #(.LUT_DEPTH(LUT_DEPTH)) u_lut (
    .idx   (lut_idx),
    .value (lut_val)
  );

  always_comb begin
    i_cur     = i_cap[n*IW +: IW];
    v_x       = XW'(v_r);
    w_x       = XW'(w_r);
    rest_x    = XW'(v_rest);
    b_x       = XW'(b_cfg);
    i_x       = XW'($signed(i_cur));
    leak      = (rest_x - v_x) >>> G_SHIFT;
    exp_x     = ge_t ? XW'(lut_val) : '0;
    v_sum     = v_x + leak + exp_x - (w_x >>> W_SHIFT) + i_x;
    w_sum     = w_x + ((((v_x - rest_x) >>> A_SHIFT) - w_x) >>> TAUW_SHIFT);
    v_new     = VW'(sat_vw(32'(v_sum), VW));
    w_new     = VW'(sat_vw(32'(w_sum), VW));
    w_spk_sum = XW'(w_new) + b_x;
    w_spk     = VW'(sat_vw(32'(w_spk_sum), VW));
    spike_now = (v_new >= V_PEAK);
  end

`ifdef ADEX_REFRACTORY_EN
  localparam int RW = $clog2(REFR_ROUNDS + 1);
  logic [RW-1:0] refr_cnt [N_NEURONS];

  assign refr_active = (refr_cnt[n] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) refr_cnt[k] <= '0;
    end else if (state == UPDATE) begin
      if (refr_active)    refr_cnt[n] <= refr_cnt[n] - 1'b1;
      else if (spike_now) refr_cnt[n] <= RW'(REFR_ROUNDS);
    end
  end
`else
  assign refr_active = 1'b0;
`endif

  // Config writes take effect immediately, even mid-round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_rest    <= VW'(V_REST_DEF);
      v_t       <= VW'(V_T_DEF);
      v_reset   <= VW'(V_RESET_DEF);
      b_cfg     <= VW'(B_DEF);
      for (int k = 0; k < N_NEURONS; k++) begin
        v_mem[k] <= VW'(V_REST_DEF);
        w_mem[k] <= '0;
      end
      n         <= '0;
      i_cap     <= '0;
      spike_acc <= '0;
      spike     <= '0;
      v_r       <= '0;
      w_r       <= '0;
      ge_t      <= 1'b0;
      lut_idx   <= '0;
      mon_v     <= VW'(V_REST_DEF);
    end else begin
      if (cfg_we) begin
        unique case (cfg_addr)
          CFG_V_REST:  v_rest  <= cfg_data;
          CFG_V_T:     v_t     <= cfg_data;
          CFG_V_RESET: v_reset <= cfg_data;
          default:     b_cfg   <= cfg_data;
        endcase
      end
      mon_v <= (32'(mon_sel) < N_NEURONS) ? v_mem[mon_sel] : '0;
      unique case (state)
        IDLE: if (tick) begin
          i_cap     <= i_syn;
          n         <= '0;
          spike_acc <= '0;
        end
        FETCH: begin
          v_r     <= v_mem[n];
          w_r     <= w_mem[n];
          ge_t    <= (v_mem[n] >= v_t);
          lut_idx <= idx_next;
        end
        UPDATE: begin
          if (refr_active) begin
            v_mem[n] <= v_reset;
            w_mem[n] <= w_new;
          end else if (spike_now) begin
            v_mem[n]     <= v_reset;
            w_mem[n]     <= w_spk;
            spike_acc[n] <= 1'b1;
          end else begin
            v_mem[n] <= v_new;
            w_mem[n] <= w_new;
          end
          if (!last) n <= n + 1'b1;
        end
        DONE: spike <= spike_acc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adex_neuron_array.sv
// Scoreboard bench for adex_neuron_array: stimulus pushes expected rounds, a monitor checks each done.
module tb_adex_neuron_array;

  typedef struct packed {
    logic [3:0]       spk;
    logic [3:0][15:0] v;
    logic [31:0]      issue;
  } exp_t;

`ifdef ADEX_REFRACTORY_EN
  localparam int REFR_LEN = 3;
`else
  localparam int REFR_LEN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [31:0] i_syn = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic [1:0]  mon_sel = '0;
  logic        busy, done;
  logic [3:0]  spike;
  logic [15:0] mon_v;

  adex_neuron_array dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .i_syn    (i_syn),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .mon_sel  (mon_sel),
    .busy     (busy),
    .done     (done),
    .spike    (spike),
    .mon_v    (mon_v)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  int n_vec = 0, n_fail = 0, issued = 0, checked = 0, done_seen = 0;

  int m_v[4], m_w[4], m_refr[4];
  int c_rest, c_vt, c_vreset, c_b;
  int lut_tab[32] = '{1, 1, 1, 1, 2, 2, 2, 2, 2, 3, 3, 3, 4, 4, 5, 5,
                      6, 6, 7, 8, 9, 10, 11, 12, 13, 15, 17, 19, 21, 23, 26, 29};

  function automatic int clamp16(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic exp_t mk(input logic [3:0] spk, input int v0, input int v1, input int v2, input int v3);
    exp_t e;
    e = '0;
    e.spk  = spk;
    e.v[0] = 16'(v0);
    e.v[1] = 16'(v1);
    e.v[2] = 16'(v2);
    e.v[3] = 16'(v3);
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    c_rest = -1024; c_vt = 512; c_vreset = -768; c_b = 64;
    for (int k = 0; k < 4; k++) begin
      m_v[k] = -1024; m_w[k] = 0; m_refr[k] = 0;
    end
  endtask

  task automatic modelRound(input logic [31:0] isyn, output exp_t e);
    e = '0;
    for (int k = 0; k < 4; k++) begin
      int v, w, leak, ex, vn, wn, iv, idx;
      v    = m_v[k];
      w    = m_w[k];
      iv   = int'($signed(isyn[k*8 +: 8]));
      leak = (c_rest - v) >>> 4;
      if (v < c_vt) ex = 0;
      else begin
        idx = (v - c_vt) >>> 4;
        if (idx > 31) idx = 31;
        ex = lut_tab[idx];
      end
      vn = clamp16(v + leak + ex - (w >>> 2) + iv);
      wn = clamp16(w + ((((v - c_rest) >>> 3) - w) >>> 5));
      if (m_refr[k] > 0) begin
        m_v[k] = c_vreset; m_w[k] = wn; m_refr[k]--;
      end else if (vn >= 2048) begin
        m_v[k] = c_vreset; m_w[k] = clamp16(wn + c_b); m_refr[k] = REFR_LEN;
        e.spk[k] = 1'b1;
      end else begin
        m_v[k] = vn; m_w[k] = wn;
      end
      e.v[k] = 16'(m_v[k]);
    end
  endtask

  task automatic waitChecked(input int target);
    int t;
    t = 0;
    while (checked < target && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (checked < target) begin
      n_vec++;
      n_fail++;
      $display("[TB] FAIL round_timeout: checked %0d, required %0d", checked, target);
    end
  endtask

  // One round: hand=1 substitutes hand-derived expectations; extra_tick injects a tick while busy.
  task automatic applyStimulus(input logic [31:0] isyn, input bit hand, input exp_t he, input bit extra_tick);
    exp_t me;
    @(negedge clk);
    i_syn = isyn;
    modelRound(isyn, me);
    if (hand) begin
      me.spk = he.spk;
      me.v   = he.v;
    end
    me.issue = 32'(cyc);
    sb.push_back(me);
    issued++;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    if (extra_tick) begin
      repeat (2) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
    waitChecked(issued);
  endtask

  task automatic cfgWrite(input logic [1:0] addr, input logic [15:0] data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
    @(negedge clk);
    cfg_we = 1'b0;
    case (addr)
      2'd0:    c_rest   = int'($signed(data));
      2'd1:    c_vt     = int'($signed(data));
      2'd2:    c_vreset = int'($signed(data));
      default: c_b      = int'($signed(data));
    endcase
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_seen++;
        if (sb.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("[TB] FAIL stray_done: pending rounds 0, required at least 1");
        end else begin
          e = sb.pop_front();
          checkOutput($sformatf("latency r%0d", checked), cyc - int'(e.issue), 9);
          @(negedge clk);
          checkOutput($sformatf("spike r%0d", checked), int'(spike), int'(e.spk));
          for (int k = 0; k < 4; k++) begin
            mon_sel = 2'(k);
            @(negedge clk);
            checkOutput($sformatf("v%0d r%0d", k, checked), int'($signed(mon_v)), int'($signed(e.v[k])));
          end
          checked++;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset spike", int'(spike), 0);
    checkOutput("reset mon_v", int'($signed(mon_v)), -1024);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] quiescent rounds");
    for (int r = 0; r < 10; r++)
      applyStimulus(32'h0, 1'b1, mk(4'h0, -1024, -1024, -1024, -1024), r == 4);

    $display("[TB] constant drive on neuron 0");
    applyStimulus(32'h0000_007F, 1'b1, mk(4'h0, -897, -1024, -1024, -1024), 1'b0);
    applyStimulus(32'h0000_007F, 1'b1, mk(4'h0, -778, -1024, -1024, -1024), 1'b0);
    applyStimulus(32'h0000_007F, 1'b1, mk(4'h0, -667, -1024, -1024, -1024), 1'b0);
    for (int r = 0; r < 30; r++) applyStimulus(32'h0000_007F, 1'b0, '0, 1'b0);

    $display("[TB] rest pinned at positive limit");
    doReset();
    cfgWrite(2'd0, 16'h7FFF);
    applyStimulus(32'h0, 1'b1, mk(4'h0, 1087, 1087, 1087, 1087), 1'b0);
    applyStimulus(32'h0, 1'b1, mk(4'hF, -768, -768, -768, -768), 1'b0);
    for (int r = 0; r < 4; r++) applyStimulus(32'h0, 1'b0, '0, 1'b0);

    $display("[TB] reset during a round");
    @(negedge clk);
    i_syn = 32'h0;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset busy", int'(busy), 0);
    checkOutput("midreset spike", int'(spike), 0);
    checkOutput("midreset mon_v", int'($signed(mon_v)), -1024);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    applyStimulus(32'h0, 1'b1, mk(4'h0, -1024, -1024, -1024, -1024), 1'b0);

    $display("[TB] driven neuron with raised rest");
    doReset();
    cfgWrite(2'd0, 16'd1500);
    for (int r = 0; r < 40; r++) applyStimulus(32'h0000_007F, 1'b0, '0, 1'b0);

    $display("[TB] negative saturation");
    doReset();
    cfgWrite(2'd0, 16'h8000);
    for (int r = 0; r < 99; r++) applyStimulus(32'h8080_8080, 1'b0, '0, 1'b0);
    applyStimulus(32'h8080_8080, 1'b1, mk(4'h0, -32768, -32768, -32768, -32768), 1'b0);

    repeat (20) @(negedge clk);
    checkOutput("done count", done_seen, issued);
    checkOutput("pending rounds", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/adex_neuron_array.md
Name: adex_neuron_array

Overview:
- Parametrised successor to the single-neuron, fixed-LUT AdEx core.
- N_NEURONS AdEx neurons are time-multiplexed over one shared fixed-point datapath.
- The exponential LUT has a configurable depth, and run-time configuration registers set the neuron constants.
- Sits under the TT top-level wrapper, which maps ui_in/uio to the cfg/input ports and uo_out to spike/monitor.

Parameters:
N_NEURONS, 4, neurons in the array (1..16).
VW, 16, signed membrane and adaptation width.
IW, 8, signed synaptic input width per neuron.
LUT_DEPTH, 32, exponential LUT entries (16, 32 or 64).
G_SHIFT, 4, leak conductance shift.
W_SHIFT, 2, adaptation-to-membrane coupling shift.
A_SHIFT, 3, subthreshold adaptation shift.
TAUW_SHIFT, 5, adaptation time-constant shift.
V_PEAK, 16'sd2048, spike detection threshold.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  start one update round (pulse)
i_syn  in  N_NEURONS*IW  per-neuron signed input current, neuron n at bits [n*IW +: IW]
cfg_we  in  1  config write strobe
cfg_addr  in  2  0=V_REST, 1=V_T, 2=V_RESET, 3=B
cfg_data  in  VW  config write data
mon_sel  in  clog2(N_NEURONS)  neuron shown on mon_v
busy  out  1  round in progress
done  out  1  one-cycle pulse at round end
spike  out  N_NEURONS  spike flags of the last completed round
mon_v  out  VW  membrane of neuron mon_sel

Behaviour:
- Reset (async, rst_n=0) puts the block in this state:
  - Config regs take their defaults: V_REST=-1024, V_T=512, V_RESET=-768, B=64.
  - All v=V_REST default (-1024), all w=0.
  - FSM=IDLE; busy=0, done=0, spike=0, mon_v=-1024.
  - Reset mid-round aborts the round with no partial state kept.
- FSM states:
  - IDLE: on tick, capture the i_syn bus, set n=0, clear the spike accumulator, and go to FETCH.
  - FETCH: register v[n], w[n] and the LUT index.
  - UPDATE: compute, then write v[n], w[n] and spike_acc[n]. If n=N_NEURONS-1 go to DONE, else n++ and go to FETCH.
  - DONE: spike<=spike_acc, done=1 for one cycle, go to IDLE.
- Latency: 2*N_NEURONS+1 cycles from the tick cycle to done. busy=1 from the cycle after tick through DONE.
- tick while busy is ignored; no queuing.
- cfg_we while busy is applied immediately. Neurons not yet updated in the current round use the new value.
- Arithmetic: all intermediate values are signed VW+2. Results are saturated to the VW signed range before they are written back.
  - leak = (V_REST - v) >>> G_SHIFT
  - exp_term:
    - 0 if v < V_T.
    - Otherwise LUT[min((v - V_T) >>> 4, LUT_DEPTH-1)].
    - LUT entries are unsigned, k -> round(2^(k*5/LUT_DEPTH)), saturated at 2047.
  - v' = sat(v + leak + exp_term - (w >>> W_SHIFT) + sext(i_syn[n]))
  - w' = sat(w + ((((v - V_REST) >>> A_SHIFT) - w) >>> TAUW_SHIFT))
  - If v' >= V_PEAK: v <= V_RESET, w <= sat(w' + B), spike_acc[n]=1.
- mon_v is registered (one-cycle latency from mon_sel or from a v write).
- spike is held stable between done pulses.

Optional Feature:
- Macro: ADEX_REFRACTORY_EN. Adds parameter REFR_ROUNDS (default 3) and a per-neuron countdown.
- With the macro defined:
  - A spike loads the counter with REFR_ROUNDS.
  - While the counter is nonzero, UPDATE forces v <= V_RESET, still updates w, suppresses spikes, and decrements the counter.
  - Counters reset to 0.
- Without the macro: no counters exist, and every round performs the full update.

Decomposition:
- Package adex_pkg:
  - FSM state enum (IDLE, FETCH, UPDATE, DONE).
  - Config address constants.
  - Reset default constants.
  - sat_vw() saturation function.
- Sub-module adex_exp_lut: parametrised by LUT_DEPTH; combinational index -> value, with contents generated from the formula above.

Test Plan:
- Reset then no input:
  - Stimulus: 10 ticks with all i_syn=0.
  - Expected: all v stay -1024, w stay 0, spike=0, and each done arrives 9 cycles after its tick (N=4).
- Constant drive:
  - Stimulus: i_syn[0]=127, others 0, repeated ticks.
  - Expected: v0 rises monotonically, spike[0]=1 in the first round where v' >= 2048; then v0 = -768 and w0 = prior w' + 64. Other neurons never spike.
- Saturation:
  - Stimulus: write V_REST=32767 via cfg, then one tick.
  - Expected: all v written <= 32767, with no wrap to negative.
- Ignored tick:
  - Stimulus: assert tick on cycle 3 of a round.
  - Expected: exactly one done, at cycle 9.
- Reset mid-round:
  - Stimulus: pulse rst_n=0 in cycle 4 of a round.
  - Expected: busy=0, spike=0, all v=-1024 immediately.
- With ADEX_REFRACTORY_EN and REFR_ROUNDS=3:
  - Stimulus: a neuron that spikes.
  - Expected: v stays -768 for the next 3 rounds with no spike; it evolves normally in the 4th.
